// File: rtl/lbp_image_host.sv
// Memory-side host for the LBP engine: loads a raster gray image, serves
// zero-latency gray reads, captures lbp writes and streams the result image out.
module lbp_image_host #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  output logic          pix_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  output logic          res_valid,
  output logic [7:0]    res_data,
  input  logic          res_ready,
  output logic          done,
  output logic          err_addr,
  output logic          err_early,
  output logic [AW-1:0] lbp_count
);

  localparam int            LW   = $clog2(IMG_W);
  localparam logic [AW-1:0] LAST = '1;
  localparam logic [AW-1:0] ONE  = AW'(1);

  typedef enum logic [1:0] {LOAD, SERVE, DRAIN, DONE} state_e;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] lbp_count_q, lbp_count_d;
  logic          pix_ready_q, gray_ready_q, res_valid_q, done_q;
  logic          err_addr_q, err_early_q;

  logic [7:0] gray_mem [2**AW];
  logic [7:0] res_mem  [2**AW];

  function automatic logic is_border(input logic [AW-1:0] a);
    logic [AW-LW-1:0] row;
    logic [LW-1:0]    col;
    row = a[AW-1:LW];
    col = a[LW-1:0];
    return (row == '0) || (row == (AW-LW)'(IMG_H-1)) || (col == '0) || (col == '1);
  endfunction

  assign wr_ptr_d    = wr_ptr_q + ONE;
  assign rd_ptr_d    = rd_ptr_q + ONE;
  assign lbp_count_d = (lbp_count_q == LAST) ? lbp_count_q : lbp_count_q + ONE;

  // Loading also zeroes the result RAM so border pixels read back as 0.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && pix_valid) begin
      gray_mem[wr_ptr_q] <= pix_data;
      res_mem[wr_ptr_q]  <= '0;
    end else if (state_q == SERVE && lbp_valid) begin
      res_mem[lbp_addr] <= lbp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lbp_count_q  <= '0;
      pix_ready_q  <= 1'b1;
      gray_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_addr_q   <= 1'b0;
      err_early_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (lbp_valid || finish) err_early_q <= 1'b1;
          if (pix_valid) begin
            wr_ptr_q <= wr_ptr_d;
            if (wr_ptr_q == LAST) begin
              state_q      <= SERVE;
              pix_ready_q  <= 1'b0;
              gray_ready_q <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (lbp_valid) begin
            lbp_count_q <= lbp_count_d;
            if (is_border(lbp_addr)) err_addr_q <= 1'b1;
          end
          if (finish) begin
            state_q      <= DRAIN;
            gray_ready_q <= 1'b0;
            res_valid_q  <= 1'b1;
            rd_ptr_q     <= '0;
          end
        end
        DRAIN: begin
          if (lbp_valid) err_early_q <= 1'b1;
          if (res_ready) begin
            rd_ptr_q <= rd_ptr_d;
            if (rd_ptr_q == LAST) begin
              state_q     <= DONE;
              res_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        default: begin
          if (lbp_valid) err_early_q <= 1'b1;
        end
      endcase
    end
  end

  assign pix_ready  = pix_ready_q;
  assign gray_ready = gray_ready_q;
  assign gray_data  = (gray_ready_q && gray_req) ? gray_mem[gray_addr] : 8'h00;
  assign res_valid  = res_valid_q;
  assign res_data   = res_valid_q ? res_mem[rd_ptr_q] : 8'h00;
  assign done       = done_q;
  assign err_addr   = err_addr_q;
  assign err_early  = err_early_q;
  assign lbp_count  = lbp_count_q;

endmodule

// File: tb/tb_lbp_image_host.sv
// Directed bench for lbp_image_host on a reduced 16x16 image; the bench acts
// as pixel source, reference LBP engine and result sink.
module tb_lbp_image_host;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int AW = 8;
  localparam int N  = W * H;

  logic          clk;
  logic          reset;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_ready;
  logic          done;
  logic          err_addr;
  logic          err_early;
  logic [AW-1:0] lbp_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] img [N];
  logic [7:0] expv [N];

  lbp_image_host #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .done(done), .err_addr(err_addr), .err_early(err_early), .lbp_count(lbp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LBP: neighbours clockwise from top-left, bit set when neighbour >= centre.
  function automatic logic [7:0] golden(input int r, input int c);
    int dr[8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    int dc[8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    logic [7:0] code = 8'h00;
    for (int i = 0; i < 8; i++)
      if (img[(r + dr[i]) * W + c + dc[i]] >= img[r * W + c]) code[i] = 1'b1;
    return code;
  endfunction

  task automatic set_image(input bit ramp);
    for (int k = 0; k < N; k++) begin
      img[k]  = ramp ? 8'(k) : 8'((k * 73 + 29) & 255);
      expv[k] = 8'h00;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_image();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = img[k];
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic write_interior(input bit finishOnLast);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        @(negedge clk);
        lbp_valid = 1'b1;
        lbp_addr  = AW'(r * W + c);
        lbp_data  = golden(r, c);
        expv[r * W + c] = golden(r, c);
        finish = finishOnLast && (r == H - 2) && (c == W - 2);
      end
  endtask

  task automatic run_drain(input bit stall);
    bit [3:0] pat = 4'b1001;
    int idx = 0;
    int p = 0;
    bit rdy;
    while (idx < N) begin
      @(negedge clk);
      lbp_valid = 1'b0;
      finish    = 1'b0;
      rdy = stall ? pat[p] : 1'b1;
      p = (p + 1) % 4;
      res_ready = rdy;
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== expv[idx]) begin
        errors++;
        $display("[TB] FAIL drain idx=%0d valid=%b data=%h required valid=1 data=%h",
                 idx, res_valid, res_data, expv[idx]);
      end
      if (rdy) idx++;
    end
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || res_valid !== 1'b0 || res_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL drain_end done=%b valid=%b data=%h required 1/0/00", done, res_valid, res_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({pix_ready, gray_ready, res_valid, done, err_addr, err_early} !== 6'b100000 ||
        lbp_count !== '0 || gray_data !== 8'h00 || res_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset flags=%b count=%0d required flags=100000 count=0",
               {pix_ready, gray_ready, res_valid, done, err_addr, err_early}, lbp_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_load_read();
    set_image(1'b1);
    load_image();
    #1;
    checks++;
    if (gray_ready !== 1'b1 || pix_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done gray_ready=%b pix_ready=%b required 1/0", gray_ready, pix_ready);
    end
    @(negedge clk);
    gray_req = 1'b1; gray_addr = AW'(17);
    #1;
    checks++;
    if (gray_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL read_17 got=%h required=11", gray_data);
    end
    gray_addr = AW'(255);
    #1;
    checks++;
    if (gray_data !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL read_255 got=%h required=ff", gray_data);
    end
    gray_req = 1'b0;
    #1;
    checks++;
    if (gray_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_idle got=%h required=00", gray_data);
    end
  endtask

  task automatic test_full_flow();
    write_interior(1'b0);
    @(negedge clk);
    lbp_valid = 1'b0;
    #1;
    checks++;
    if (lbp_count !== AW'((W - 2) * (H - 2)) || err_addr !== 1'b0 || err_early !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_count count=%0d err_addr=%b err_early=%b required %0d/0/0",
               lbp_count, err_addr, err_early, (W - 2) * (H - 2));
    end
    finish = 1'b1;
    run_drain(1'b0);
  endtask

  task automatic test_early();
    set_image(1'b0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = img[k];
      finish    = (k == 50);
      lbp_valid = (k == 100);
      lbp_addr  = AW'(32);
      lbp_data  = 8'h77;
      gray_req  = (k == 60);
      gray_addr = AW'(10);
      #1;
      if (k == 51) begin
        checks++;
        if (err_early !== 1'b1 || pix_ready !== 1'b1 || gray_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL early_finish err_early=%b pix_ready=%b gray_ready=%b required 1/1/0",
                   err_early, pix_ready, gray_ready);
        end
      end
      if (k == 60) begin
        checks++;
        if (gray_data !== 8'h00) begin
          errors++;
          $display("[TB] FAIL early_read got=%h required=00", gray_data);
        end
      end
      if (k == 101) begin
        checks++;
        if (lbp_count !== '0) begin
          errors++;
          $display("[TB] FAIL early_count got=%0d required=0", lbp_count);
        end
      end
      if (k == N - 1) begin
        checks++;
        if (gray_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL early_gray_ready got=%b required=0", gray_ready);
        end
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    #1;
    checks++;
    if (gray_ready !== 1'b1 || err_addr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL early_loaded gray_ready=%b err_addr=%b required 1/0", gray_ready, err_addr);
    end
  endtask

  task automatic test_border();
    logic [7:0] bdata [3] = '{8'hA5, 8'h5A, 8'h3C};
    int         baddr [3] = '{0, W - 1, (H - 1) * W};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lbp_valid = 1'b1;
      lbp_addr  = AW'(baddr[i]);
      lbp_data  = bdata[i];
      expv[baddr[i]] = bdata[i];
    end
    @(negedge clk);
    lbp_valid = 1'b0;
    #1;
    checks++;
    if (err_addr !== 1'b1 || lbp_count !== AW'(3)) begin
      errors++;
      $display("[TB] FAIL border err_addr=%b count=%0d required 1/3", err_addr, lbp_count);
    end
  endtask

  task automatic test_drain_stall();
    write_interior(1'b1);
    run_drain(1'b1);
    checks++;
    if (lbp_count !== AW'(3 + (W - 2) * (H - 2))) begin
      errors++;
      $display("[TB] FAIL stall_count got=%0d required=%0d", lbp_count, 3 + (W - 2) * (H - 2));
    end
    @(negedge clk);
    lbp_valid = 1'b1;
    @(negedge clk);
    lbp_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || lbp_count !== AW'(3 + (W - 2) * (H - 2)) || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_hold done=%b count=%0d res_valid=%b", done, lbp_count, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    set_image(1'b1);
    load_image();
    @(negedge clk);
    lbp_valid = 1'b1; lbp_addr = AW'(0); lbp_data = 8'h12;
    @(negedge clk);
    lbp_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (pix_ready !== 1'b1 || gray_ready !== 1'b0 || done !== 1'b0 || err_addr !== 1'b0 ||
        lbp_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid pix_ready=%b gray_ready=%b done=%b err_addr=%b count=%0d",
               pix_ready, gray_ready, done, err_addr, lbp_count);
    end
    @(negedge clk);
    reset = 1'b1;
    load_image();
    test_full_flow();
  endtask

  initial begin
    reset = 1'b0; pix_valid = 1'b0; pix_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; res_ready = 1'b0;
    test_reset();
    test_load_read();
    test_full_flow();
    pulse_reset();
    test_early();
    test_border();
    test_drain_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
